// File: rtl/nt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nt_pkg
// Description : Shared constants for the neurotransmitter level integrator:
//               channel indices, default channel count, level width, fast
//               step size, decay divider and the per-channel update action.
// Revision    : 1.0 - initial release
// ============================================================================
package nt_pkg;

  // Channel indices into the packed per-channel buses
  localparam int CORT = 0;
  localparam int DOP  = 1;
  localparam int GABA = 2;
  localparam int NE   = 3;
  localparam int SER  = 4;

  localparam int NT_NUM_CH      = 5;
  localparam int NT_LEVEL_W     = 8;
  localparam int NT_FAST_STEP   = 4;
  localparam int NT_DECAY_DIV   = 8;
  localparam int NT_PRESCALE_W  = 4;

  // What a channel does with its level on an update tick
  typedef enum logic [1:0] {
    ACT_HOLD  = 2'd0,
    ACT_UP    = 2'd1,
    ACT_DOWN  = 2'd2,
    ACT_DECAY = 2'd3
  } nt_act_e;

endpackage
`default_nettype wire

// File: rtl/nt_channel_integrator.sv
`default_nettype none
// ============================================================================
// Module      : nt_channel_integrator
// Description : One channel's level register with saturating step up/down and
//               homeostatic one-step decay toward the mid-scale baseline.
// Ports       : clk, rst_n   - clock, asynchronous active-low reset
//               i_upd        - update strobe (prescaler tick)
//               i_decay      - decay strobe (only meaningful with i_upd)
//               i_inc/i_dec  - increase / decrease request
//               i_fast       - select FAST_STEP instead of 1
//               o_level      - current level
// Revision    : 1.0 - initial release
// ============================================================================
module nt_channel_integrator
  import nt_pkg::*;
#(
  parameter int LEVEL_W   = NT_LEVEL_W,
  parameter int FAST_STEP = NT_FAST_STEP
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_upd,
  input  logic               i_decay,
  input  logic               i_inc,
  input  logic               i_dec,
  input  logic               i_fast,
  output logic [LEVEL_W-1:0] o_level
);

  localparam int EXT_W = LEVEL_W + 1;
  localparam logic [EXT_W-1:0]   C_MAX  = {1'b0, {LEVEL_W{1'b1}}};
  localparam logic [EXT_W-1:0]   C_FAST = EXT_W'(FAST_STEP);
  localparam logic [EXT_W-1:0]   C_ONE  = EXT_W'(1);
  localparam logic [LEVEL_W-1:0] C_BASE = {1'b1, {(LEVEL_W-1){1'b0}}};

  logic [LEVEL_W-1:0] r_level;
  logic [EXT_W-1:0]   w_ext;
  logic [EXT_W-1:0]   w_step;
  logic [EXT_W-1:0]   w_sum;
  logic [LEVEL_W-1:0] w_up;
  logic [LEVEL_W-1:0] w_down;
  logic [LEVEL_W-1:0] w_next;
  nt_act_e            w_act;

  // One extra bit of headroom so level+step cannot wrap before clamping
  assign w_ext  = {1'b0, r_level};
  assign w_step = i_fast ? C_FAST : C_ONE;
  assign w_sum  = w_ext + w_step;
  assign w_up   = (w_sum > C_MAX) ? {LEVEL_W{1'b1}} : w_sum[LEVEL_W-1:0];
  assign w_down = (w_ext < w_step) ? '0 : (r_level - w_step[LEVEL_W-1:0]);

  always_comb begin
    w_act = ACT_HOLD;
    case ({i_inc, i_dec})
      2'b10:   w_act = ACT_UP;
      2'b01:   w_act = ACT_DOWN;
      2'b00:   w_act = i_decay ? ACT_DECAY : ACT_HOLD;
      default: w_act = ACT_HOLD;   // conflicting requests freeze the channel
    endcase
  end

  always_comb begin
    w_next = r_level;
    case (w_act)
      ACT_UP:   w_next = w_up;
      ACT_DOWN: w_next = w_down;
      ACT_DECAY: begin
        if (r_level > C_BASE)
          w_next = r_level - 1'b1;
        else if (r_level < C_BASE)
          w_next = r_level + 1'b1;
      end
      default:  w_next = r_level;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_level <= C_BASE;
    else if (i_upd)
      r_level <= w_next;
  end

  assign o_level = r_level;

endmodule
`default_nettype wire

// File: rtl/nt_multi_level_integrator.sv
`default_nettype none
// ============================================================================
// Module      : nt_multi_level_integrator
// Description : Multi-channel neurotransmitter level integrator. A shared
//               prescaler produces update ticks; a decay counter marks every
//               DECAY_DIV-th tick for homeostatic drift toward baseline.
// Ports       : clk, rst_n   - clock, asynchronous active-low reset
//               i_ena        - global enable, low freezes all state
//               i_prescale   - tick every i_prescale+1 enabled cycles
//               i_inc/i_dec  - per-channel increase / decrease requests
//               i_fast       - per-channel fast step select
//               o_level      - packed levels, channel c at [c*LEVEL_W +: LEVEL_W]
//               o_level_q    - packed top two level bits, channel c at [2c +: 2]
//               o_sat_hi/lo  - level at full scale / zero
//               o_tick       - high in the cycle the updated levels appear
// Revision    : 1.0 - initial release
// ============================================================================
module nt_multi_level_integrator
  import nt_pkg::*;
#(
  parameter int NUM_CH     = NT_NUM_CH,
  parameter int LEVEL_W    = NT_LEVEL_W,
  parameter int PRESCALE_W = NT_PRESCALE_W,
  parameter int FAST_STEP  = NT_FAST_STEP,
  parameter int DECAY_DIV  = NT_DECAY_DIV
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_ena,
  input  logic [PRESCALE_W-1:0]     i_prescale,
  input  logic [NUM_CH-1:0]         i_inc,
  input  logic [NUM_CH-1:0]         i_dec,
  input  logic [NUM_CH-1:0]         i_fast,
  output logic [NUM_CH*LEVEL_W-1:0] o_level,
  output logic [NUM_CH*2-1:0]       o_level_q,
  output logic [NUM_CH-1:0]         o_sat_hi,
  output logic [NUM_CH-1:0]         o_sat_lo,
  output logic                      o_tick
);

  localparam int DCNT_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [DCNT_W-1:0] C_DCNT_LAST = DCNT_W'(DECAY_DIV - 1);

  logic [PRESCALE_W-1:0] r_pcnt;
  logic [DCNT_W-1:0]     r_dcnt;
  logic                  r_tick;
  logic                  w_tick;
  logic                  w_decay;
  logic [LEVEL_W-1:0]    w_lvl [NUM_CH];

  // ">=" rather than "==" so that lowering the prescale below the running
  // count fires on the next enabled cycle instead of waiting for a wrap.
  assign w_tick  = i_ena && (r_pcnt >= i_prescale);
  assign w_decay = w_tick && (r_dcnt == C_DCNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcnt <= '0;
      r_dcnt <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_tick;
      if (w_tick) begin
        r_pcnt <= '0;
        r_dcnt <= (r_dcnt == C_DCNT_LAST) ? '0 : r_dcnt + DCNT_W'(1);
      end else if (i_ena) begin
        r_pcnt <= r_pcnt + PRESCALE_W'(1);
      end
    end
  end

  // Registered so the output carries no combinational path from i_ena/i_prescale
  assign o_tick = r_tick;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    nt_channel_integrator #(
      .LEVEL_W   (LEVEL_W),
      .FAST_STEP (FAST_STEP)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_upd   (w_tick),
      .i_decay (w_decay),
      .i_inc   (i_inc[c]),
      .i_dec   (i_dec[c]),
      .i_fast  (i_fast[c]),
      .o_level (w_lvl[c])
    );

    assign o_level[c*LEVEL_W +: LEVEL_W] = w_lvl[c];
    assign o_level_q[2*c +: 2]           = w_lvl[c][LEVEL_W-1 -: 2];
    assign o_sat_hi[c]                   = &w_lvl[c];
    assign o_sat_lo[c]                   = ~|w_lvl[c];
  end

endmodule
`default_nettype wire

// File: tb/tb_nt_multi_level_integrator.sv
`default_nettype none
// ============================================================================
// Module      : tb_nt_multi_level_integrator
// Description : Self-checking bench for nt_multi_level_integrator with a
//               behavioural reference model of prescaler, decay and levels.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nt_multi_level_integrator;
  import nt_pkg::*;

  localparam int NCH  = 5;
  localparam int LW   = 8;
  localparam int BASE = 128;
  localparam int LMAX = 255;
  localparam int FSTEP = 4;
  localparam int DDIV = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ena;
  logic [3:0]        prescale;
  logic [NCH-1:0]    inc, dec, fast;
  logic [NCH*LW-1:0] level;
  logic [NCH*2-1:0]  level_q;
  logic [NCH-1:0]    sat_hi, sat_lo;
  logic              tick;

  int n_assert = 0;
  int n_fail   = 0;
  int n_ticks  = 0;

  // Reference model state
  int m_lvl [NCH];
  int m_pcnt, m_dcnt;
  bit m_tick;

  always #5 clk = ~clk;

  nt_multi_level_integrator dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_ena      (ena),
    .i_prescale (prescale),
    .i_inc      (inc),
    .i_dec      (dec),
    .i_fast     (fast),
    .o_level    (level),
    .o_level_q  (level_q),
    .o_sat_hi   (sat_hi),
    .o_sat_lo   (sat_lo),
    .o_tick     (tick)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) m_lvl[c] = BASE;
    m_pcnt = 0;
    m_dcnt = 0;
    m_tick = 0;
  endtask

  // One rising edge of the specified behaviour
  task automatic model_edge();
    bit t, dk;
    int s;
    if (ena) begin
      t = (m_pcnt >= int'(prescale));
      if (t) begin
        dk = (m_dcnt == DDIV - 1);
        for (int c = 0; c < NCH; c++) begin
          s = fast[c] ? FSTEP : 1;
          if (inc[c] && !dec[c])      m_lvl[c] = (m_lvl[c] + s > LMAX) ? LMAX : m_lvl[c] + s;
          else if (dec[c] && !inc[c]) m_lvl[c] = (m_lvl[c] - s < 0) ? 0 : m_lvl[c] - s;
          else if (!inc[c] && !dec[c] && dk) begin
            if (m_lvl[c] > BASE)      m_lvl[c]--;
            else if (m_lvl[c] < BASE) m_lvl[c]++;
          end
        end
        m_dcnt = (m_dcnt + 1) % DDIV;
        m_pcnt = 0;
      end else begin
        m_pcnt++;
      end
      m_tick = t;
    end else begin
      m_tick = 0;
    end
  endtask

  task automatic check_all(input string tag);
    logic [NCH*LW-1:0] el;
    logic [NCH*2-1:0]  eq;
    logic [NCH-1:0]    eh, elo;
    logic [7:0]        v;
    for (int c = 0; c < NCH; c++) begin
      v = m_lvl[c][7:0];
      el[c*LW +: LW] = v;
      eq[2*c +: 2]   = v[7:6];
      eh[c]          = (m_lvl[c] == LMAX);
      elo[c]         = (m_lvl[c] == 0);
    end
    chk({tag, ".level"},   64'(level),   64'(el));
    chk({tag, ".level_q"}, 64'(level_q), 64'(eq));
    chk({tag, ".sat_hi"},  64'(sat_hi),  64'(eh));
    chk({tag, ".sat_lo"},  64'(sat_lo),  64'(elo));
    chk({tag, ".tick"},    64'(tick),    64'(m_tick));
  endtask

  task automatic step(input string tag, input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      if (tick) n_ticks++;
      check_all(tag);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [7:0] lvl(input int c);
    return level[c*LW +: LW];
  endfunction

  initial begin
    int guard;
    rst_n = 1'b0; ena = 1'b0; prescale = '0; inc = '0; dec = '0; fast = '0;
    model_reset();
    #12;
    check_all("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Slow increment on GABA with tick every 4th cycle
    ena = 1'b1; prescale = 4'd3; inc = 5'b00100;
    n_ticks = 0;
    step("gaba_inc", 12);
    chk("gaba_after_3_ticks", 64'(lvl(GABA)), 64'd131);
    chk("gaba_tick_count",    64'(n_ticks),   64'd3);

    // Saturate CORT at full scale
    do_reset();
    prescale = 4'd0; inc = 5'b00001; dec = '0; fast = 5'b00001;
    step("cort_up", 31);
    fast = '0;
    step("cort_up1", 1);
    chk("cort_253", 64'(lvl(CORT)), 64'd253);
    fast = 5'b00001;
    step("cort_sat", 1);
    chk("cort_255",    64'(lvl(CORT)),    64'd255);
    chk("cort_sat_hi", 64'(sat_hi[CORT]), 64'd1);
    step("cort_hold", 3);
    chk("cort_still_255", 64'(lvl(CORT)), 64'd255);

    // Saturate DOP at zero, then conflicting requests hold
    do_reset();
    prescale = 4'd0; inc = '0; dec = 5'b00010; fast = 5'b00010;
    step("dop_down", 31);
    fast = '0;
    step("dop_down1", 2);
    chk("dop_2", 64'(lvl(DOP)), 64'd2);
    fast = 5'b00010;
    step("dop_sat", 1);
    chk("dop_0",      64'(lvl(DOP)),    64'd0);
    chk("dop_sat_lo", 64'(sat_lo[DOP]), 64'd1);
    inc = 5'b00010;
    step("dop_conflict", 3);
    chk("dop_conflict_0", 64'(lvl(DOP)), 64'd0);

    // Homeostatic decay of NE toward baseline
    do_reset();
    prescale = 4'd0; inc = 5'b01000; dec = '0; fast = '0;
    step("ne_up", 3);
    chk("ne_131", 64'(lvl(NE)), 64'd131);
    inc = '0;
    step("ne_decay", 8);
    chk("ne_130", 64'(lvl(NE)), 64'd130);
    step("ne_decay", 8);
    chk("ne_129",  64'(lvl(NE)),  64'd129);
    chk("ser_128", 64'(lvl(SER)), 64'd128);

    // Enable gap mid-count, then prescale lowered below the running count
    do_reset();
    prescale = 4'd3; inc = 5'b10000; fast = '0;
    step("gap_pre", 2);
    ena = 1'b0;
    step("gap_off", 5);
    ena = 1'b1;
    step("gap_post", 10);
    prescale = 4'd7;
    guard = 0;
    while (m_pcnt != 5 && guard < 40) begin
      step("ps_wait", 1);
      guard++;
    end
    chk("ps_reach_pcnt5", 64'(guard < 40), 64'd1);
    prescale = 4'd1;
    step("ps_drop", 1);
    chk("ps_drop_tick", 64'(tick), 64'd1);

    // Randomized traffic with an asynchronous reset in the middle
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) prescale = 4'($urandom_range(0, 3));
      ena  = ($urandom_range(0, 9) != 0);
      inc  = 5'($urandom);
      dec  = 5'($urandom);
      fast = 5'($urandom);
      step("rand", 1);
      if (i == 200) begin
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_level", 64'(level), 64'h80_80_80_80_80);
        chk("async_rst_tick",  64'(tick),  64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
